// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sdf_stage_ctrl
// Sequencer for one radix-2 SDF FFT stage: delay-line step, butterfly select,
// twiddle address, output valid and end-of-frame flush.
// Rev    : 1.0
// ============================================================================
module sdf_stage_ctrl #(
  parameter int N     = 32,
  parameter int STAGE = 0,
  parameter int CNT_W = 5,
  parameter int TW_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            sr_en_o,
  output logic            bf_sel_o,
  output logic            tw_en_o,
  output logic [TW_W-1:0] tw_addr_o,
  output logic            out_valid_o,
  output logic            frame_done_o,
  output logic            busy_o
);

  localparam int D     = N >> (STAGE + 1);
  localparam int LOG2D = $clog2(D);

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_D    = CNT_W'(D);
  localparam logic [CNT_W-1:0] C_DM1  = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;

  logic             w_ready;
  logic             w_accept;
  logic             w_sr_en;
  logic             w_bf_sel;
  logic             w_out_valid;
  logic             w_tw_en;
  logic [TW_W-1:0]  w_tw_addr;
  logic [CNT_W-1:0] w_out_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        primed_d = 1'b0;
        if (w_accept) begin
          state_d = S_RUN;
          cnt_d   = C_ONE;
          if (C_ONE == C_D) primed_d = 1'b1;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          cnt_d = cnt_q + C_ONE;
          if (cnt_d == C_D) primed_d = 1'b1;
        end else if (cnt_q == '0) begin
          // A frame just ended and no new one follows: drain the delay line.
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_DM1) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          primed_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        primed_d = 1'b0;
      end
    endcase
  end

  assign w_ready     = (state_q != S_FLUSH);
  assign w_accept    = in_valid_i && w_ready;
  assign w_sr_en     = w_accept || (state_q == S_FLUSH);
  // Only accepted samples can select the butterfly, so flush stays in bypass.
  assign w_bf_sel    = w_accept && cnt_q[LOG2D];
  assign w_out_valid = w_sr_en && (primed_q || (cnt_q >= C_D));
  assign w_tw_en     = w_out_valid && !w_bf_sel;
  assign w_tw_addr   = TW_W'((cnt_q & C_DM1) << STAGE);
  assign w_out_idx   = cnt_q - C_D;

  assign in_ready_o   = w_ready;
  assign sr_en_o      = w_sr_en;
  assign bf_sel_o     = w_bf_sel;
  assign out_valid_o  = w_out_valid;
  assign tw_en_o      = w_tw_en;
  assign tw_addr_o    = w_tw_en ? w_tw_addr : '0;
  assign frame_done_o = w_out_valid && (w_out_idx == C_LAST);
  assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sdf_stage_ctrl
// Bench for sdf_stage_ctrl at STAGE 0 (D=16) and STAGE 3 (D=2) side by side.
// Rev    : 1.0
// ============================================================================
module tb_sdf_stage_ctrl;

  localparam int N = 32;

  logic clk;
  logic rst;
  logic in_valid;

  logic       rdy0, sr0, bf0, twen0, ov0, fd0, busy0;
  logic [3:0] twa0;
  logic       rdy3, sr3, bf3, twen3, ov3, fd3, busy3;
  logic [3:0] twa3;

  logic [10:0] act [2];
  assign act[0] = {rdy0, sr0, bf0, twen0, twa0, ov0, fd0, busy0};
  assign act[1] = {rdy3, sr3, bf3, twen3, twa3, ov3, fd3, busy3};

  sdf_stage_ctrl #(.N(32), .STAGE(0), .CNT_W(5), .TW_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .sr_en_o(sr0), .bf_sel_o(bf0), .tw_en_o(twen0), .tw_addr_o(twa0),
    .out_valid_o(ov0), .frame_done_o(fd0), .busy_o(busy0)
  );

  sdf_stage_ctrl #(.N(32), .STAGE(3), .CNT_W(5), .TW_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy3),
    .sr_en_o(sr3), .bf_sel_o(bf3), .tw_en_o(twen3), .tw_addr_o(twa3),
    .out_valid_o(ov3), .frame_done_o(fd3), .busy_o(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int  n_cmp = 0;
  int  n_err = 0;
  bit  started = 1'b0;
  int  req_seq = 0;
  int  req_id = 0;
  int  done_seq = 0;

  // Model state: samples accepted since the session began, flush progress.
  int  mk [2];
  int  mf [2];
  bit  mfl [2];
  bit  msess [2];
  int  cnt [2][7];
  int  base [2][7];
  logic [10:0] e_v;

  function automatic int d_of(input int i);
    return (i == 0) ? 16 : 2;
  endfunction

  function automatic int s_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [10:0] model_out(input int i, input bit vin);
    int  d, s, p, idx, twa;
    bit  rdy, sr, bf, twen, ov, fd, bsy;
    d = d_of(i); s = s_of(i);
    sr = 0; bf = 0; twen = 0; ov = 0; fd = 0; twa = 0;
    rdy = !mfl[i];
    bsy = msess[i] || mfl[i];
    if (mfl[i]) begin
      sr   = 1;
      ov   = 1;
      twen = 1;
      idx  = N - d + mf[i];
      twa  = (mf[i] << s) % 16;
      fd   = (idx == N - 1);
    end else if (vin) begin
      p    = mk[i] % N;
      sr   = 1;
      bf   = (p % (2 * d)) >= d;
      ov   = (mk[i] >= d);
      idx  = (((mk[i] - d) % N) + N) % N;
      twen = ov && !bf;
      twa  = twen ? ((p % d) << s) % 16 : 0;
      fd   = ov && (idx == N - 1);
    end
    return {rdy, sr, bf, twen, 4'(twa), ov, fd, bsy};
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      mk[i] = 0; mf[i] = 0; mfl[i] = 0; msess[i] = 0;
    end else if (mfl[i]) begin
      mf[i]++;
      if (mf[i] == d_of(i)) begin
        mfl[i] = 0; msess[i] = 0; mk[i] = 0; mf[i] = 0;
      end
    end else if (in_valid) begin
      msess[i] = 1;
      mk[i]++;
    end else if (msess[i] && (mk[i] % N == 0)) begin
      mfl[i] = 1;
      mf[i]  = 0;
    end
  endtask

  function automatic string metric_name(input int m);
    case (m)
      0: return "sr_en_cycles";
      1: return "out_valid_cycles";
      2: return "frame_done_pulses";
      3: return "bf_sel_cycles";
      4: return "flush_cycles";
      5: return "tw_en_cycles";
      default: return "tw_addr_sum";
    endcase
  endfunction

  // Hand-computed totals: id 1 = one frame then flush, id 2 = two back-to-back frames.
  function automatic int exp_metric(input int id, input int i, input int m);
    int t [7];
    if (id == 1 && i == 0)      t = '{48, 32, 1, 16, 16, 16, 120};
    else if (id == 1)           t = '{34, 32, 1, 16, 2, 16, 64};
    else if (i == 0)            t = '{80, 64, 2, 32, 16, 32, 240};
    else                        t = '{66, 64, 2, 32, 2, 32, 128};
    return t[m];
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic serve(input int id);
    if (id == 0) begin
      lit("idle_outputs_dut0", int'(act[0]), 'h400);
      lit("idle_outputs_dut3", int'(act[1]), 'h400);
    end else if (id == 1 || id == 2) begin
      for (int i = 0; i < 2; i++)
        for (int m = 0; m < 7; m++)
          lit($sformatf("%s_dut%0d_case%0d", metric_name(m), i, id),
              cnt[i][m] - base[i][m], exp_metric(id, i, m));
    end else if (id == 3) begin
      lit("wait_bound_expired", 1, 0);
    end else begin
      for (int i = 0; i < 2; i++)
        for (int m = 0; m < 7; m++)
          base[i][m] = cnt[i][m];
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int i = 0; i < 2; i++) begin
        e_v = model_out(i, in_valid);
        n_cmp++;
        if (act[i] !== e_v) begin
          n_err++;
          $display("FAIL cycle_dut%0d t=%0t rdy,sr,bf,twen,twa[4],ov,fd,busy got %b required %b",
                   i, $time, act[i], e_v);
        end
        cnt[i][0] += int'(act[i][9]);
        cnt[i][1] += int'(act[i][2]);
        cnt[i][2] += int'(act[i][1]);
        cnt[i][3] += int'(act[i][8]);
        cnt[i][4] += int'(!act[i][10]);
        cnt[i][5] += int'(act[i][7]);
        cnt[i][6] += int'(act[i][6:3]);
      end
    end
    if (req_seq != done_seq) begin
      done_seq = req_seq;
      serve(req_id);
    end
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic req(input int id);
    req_id = id;
    req_seq++;
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input int n, input int gap_at, input int gap_len);
    for (int s = 0; s < n; s++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (s == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!busy0 && !busy3) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) req(3);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mf[i] = 0; mfl[i] = 0; msess[i] = 0;
      for (int m = 0; m < 7; m++) begin
        cnt[i][m] = 0;
        base[i][m] = 0;
      end
    end
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    req(0);

    // Single frame followed by flush.
    req(9); drive(32, -1, 0); wait_idle(); req(1);

    // Two back-to-back frames.
    req(9); drive(64, -1, 0); wait_idle(); req(2);

    // Three-cycle gap after sample 5.
    req(9); drive(32, 5, 3); wait_idle(); req(1);

    // Reset on the fifth flush cycle of the D=16 stage, then a clean frame.
    drive(32, -1, 0);
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (!rdy0) begin
          found = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!found) req(3);
    end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req(0);
    req(9); drive(32, -1, 0); wait_idle(); req(1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
Sequencer for one radix-2 single-path delay-feedback (SDF) stage of the 32-point FFT. It drives the stage's delay-line shift enable, butterfly/bypass select, twiddle ROM address and output-valid. After the last frame it flushes the delay line so every frame yields exactly N outputs. One instance sits beside each stage's delay line and butterfly.

Parameters:
N, 32, FFT length (power of two, 4..64)
STAGE, 0, stage index 0..log2(N)-1; delay length D = N >> (STAGE+1)
CNT_W, 5, log2(N), sample counter width
TW_W, 4, log2(N/2), twiddle ROM address width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input sample present this cycle
in_ready  output  1  controller accepts a sample this cycle
sr_en  output  1  delay line and butterfly advance one step
bf_sel  output  1  1 = butterfly (sum out, difference into delay line); 0 = bypass (input into delay line, delay output out)
tw_en  output  1  current output needs a twiddle multiply
tw_addr  output  TW_W  twiddle ROM index into W_N^k, k < N/2
out_valid  output  1  stage output valid this cycle
frame_done  output  1  one-cycle pulse on the Nth output of a frame
busy  output  1  state != IDLE

Behaviour:
- Accept = in_valid && in_ready. in_ready = 0 only in FLUSH.
- States:
  - IDLE: cnt = 0, primed = 0. On accept, go to RUN; that sample is index 0.
  - RUN:
    - On accept: cnt <= (cnt+1) mod N. If cnt reaches D, set primed = 1.
    - No accept (mid-frame gap): every control output is 0 and cnt is held. Gaps are allowed at any index.
    - Accept of index N-1 moves cnt to 0. Next cycle with cnt == 0: accept stays in RUN (back-to-back frame, no bubble); no accept goes to FLUSH.
  - FLUSH:
    - sr_en = 1 every cycle for D cycles; cnt counts 0..D-1; in_valid ignored.
    - Leaves to IDLE after the cycle with cnt == D-1; primed cleared.
- Control outputs (combinational from state, cnt and accept):
  - sr_en = accept (RUN), or 1 (FLUSH).
  - bf_sel = sr_en && cnt[log2(D)], i.e. the upper half of each 2D block. In FLUSH bf_sel is always 0.
  - out_valid = sr_en && (primed || cnt >= D). The first output of the first frame is on the accept of index D. Output index = (cnt - D) mod N.
  - tw_en = out_valid && !bf_sel (differences leaving the delay line).
  - tw_addr = (cnt mod D) << STAGE, truncated to TW_W; 0 when tw_en = 0.
  - frame_done = out_valid && output index == N-1.
- Latency: each frame produces exactly N out_valid cycles, starting D accepted samples after its first sample. The last frame is completed by the D flush cycles.
- busy = 1 in RUN and FLUSH.
- Reset at any time (including mid-frame or mid-FLUSH): next cycle is IDLE, cnt = 0, primed = 0. All outputs are 0 except in_ready = 1. Stale delay-line contents are never flagged valid.
- D = 1 (last stage): bf_sel alternates with cnt[0]; tw_addr is always 0.

Test Plan:
1. Assert rst for 2 cycles, then release with in_valid = 0 -> all outputs 0, in_ready = 1, busy = 0.
2. STAGE=0 (D=16), 32 contiguous samples, then idle:
   - sr_en high 48 cycles; out_valid high 32 cycles, first on the 17th accept.
   - bf_sel = 1 on accepts 16..31.
   - FLUSH: 16 cycles with in_ready = 0, tw_addr 0..15.
   - frame_done on the last flush cycle, then IDLE.
3. STAGE=0, 64 back-to-back samples -> no FLUSH between frames; out_valid continuous 64 cycles incl. a 16-cycle flush; frame_done on output indices 31 and 63.
4. STAGE=0, in_valid low for 3 cycles after sample 5 -> sr_en and out_valid 0 during the gap, cnt held. Output count and tw_addr sequence are identical to scenario 2.
5. STAGE=3 (D=2), one frame -> tw_addr on tw_en cycles = 0,8,0,8,...; bf_sel pattern 0011 repeating; 2 flush cycles.
6. STAGE=0, rst asserted on the 5th FLUSH cycle -> IDLE next cycle, all outputs 0. A following frame behaves exactly as in scenario 2.
